// File: rtl/iir_out_decim.sv
// Accumulate-and-dump decimator for the look-ahead IIR output, followed by a small FIFO with a registered head.
// Optional macro IIR_DECIM_ROUND_EN selects round-half-up with clipping instead of a floor shift.
module iir_out_decim #(
  parameter int DW         = 15,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      x_in,
  input  logic               x_valid,
  output logic [DW-1:0]      y_out,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ovf
);

`ifdef IIR_DECIM_ROUND_EN
  localparam int AW = DW + LOG2_DECIM + 1;
`else
  localparam int AW = DW + LOG2_DECIM;
`endif
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [LOG2_DECIM-1:0] PHASE_MAX  = '1;
  localparam logic [FIFO_AW:0]      LEVEL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]      LEVEL_ONE  = (FIFO_AW+1)'(1);

  logic signed [AW-1:0]   acc_reg, acc_next;
  logic [LOG2_DECIM-1:0]  phase_reg, phase_next;
  logic signed [AW-1:0]   x_ext, sum;
  logic                   push;
  logic [DW-1:0]          result;

  assign x_ext = {{(AW-DW){x_in[DW-1]}}, x_in};

  // Accumulator state register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      phase_reg <= '0;
    end else begin
      acc_reg   <= acc_next;
      phase_reg <= phase_next;
    end
  end

  // Next state: phase 0 restarts the sum so a stale accumulator never leaks into a new block
  always_comb begin
    acc_next   = acc_reg;
    phase_next = phase_reg;
    sum        = ((phase_reg == '0) ? '0 : acc_reg) + x_ext;
    if (x_valid) begin
      if (phase_reg == PHASE_MAX) begin
        phase_next = '0;
      end else begin
        acc_next   = sum;
        phase_next = phase_reg + 1'b1;
      end
    end
  end

`ifdef IIR_DECIM_ROUND_EN
  localparam logic signed [AW-1:0] HALF = AW'(1) << (LOG2_DECIM - 1);
  localparam logic signed [AW-1:0] RMAX = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] RMIN = -AW'(1 << (DW - 1));
  logic signed [AW-1:0] shifted;
`endif

  // Output decode: push on the dump cycle
  always_comb begin
    push = x_valid && (phase_reg == PHASE_MAX);
`ifdef IIR_DECIM_ROUND_EN
    shifted = (sum + HALF) >>> LOG2_DECIM;
    if (shifted > RMAX)      result = RMAX[DW-1:0];
    else if (shifted < RMIN) result = RMIN[DW-1:0];
    else                     result = shifted[DW-1:0];
`else
    result = sum[AW-1:LOG2_DECIM];
`endif
  end

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [FIFO_AW:0]   level_reg;
  logic [DW-1:0]      head_reg;
  logic               ovf_reg;
  logic               pop, full, wr_en;

  assign pop        = y_ready && (level_reg != '0);
  assign full       = (level_reg == LEVEL_FULL);
  assign wr_en      = push && (!full || pop);
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= result;
  end

  // The head register mirrors mem[rd_ptr]; it is refilled from the next slot or the incoming push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_inc;
      if (push && full && !pop) ovf_reg <= 1'b1;
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (pop) begin
        if (level_reg > LEVEL_ONE) head_reg <= mem[rd_ptr_inc];
        else if (wr_en)            head_reg <= result;
        else                       head_reg <= '0;
      end else if (level_reg == '0 && wr_en) begin
        head_reg <= result;
      end
    end
  end

  assign y_out      = head_reg;
  assign y_valid    = (level_reg != '0);
  assign fifo_level = level_reg;
  assign ovf        = ovf_reg;

endmodule
